// File: rtl/pool_scale_pkg.sv
// Shared constants and FSM encoding for the average-pooling scale stage.
package pool_scale_pkg;

    localparam logic [15:0] FP16_QNAN     = 16'h7E00;
    localparam logic [15:0] FP16_INF      = 16'h7C00;
    localparam int          FP16_EXP_BIAS = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/pool_scale_fp16_mul.sv
// Pipelined IEEE half-precision multiplier, round-to-nearest-even, subnormals flushed.
// result/rdy appear MUL_LAT cycles after operation_nd; flush kills every op in flight.
module fp16_mul
    import pool_scale_pkg::*;
#(
    parameter int MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        operation_nd,
    output logic [15:0] result,
    output logic        rdy
);

    function automatic logic [15:0] mul_core(input logic [15:0] x, input logic [15:0] y);
        logic              sign;
        logic              x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
        logic [21:0]       prod;
        logic [9:0]        mant;
        logic              guard, sticky, inc;
        logic [10:0]       mant_r;
        logic signed [7:0] exp;
        logic [15:0]       res;

        sign   = x[15] ^ y[15];
        x_zero = (x[14:10] == 5'd0);
        y_zero = (y[14:10] == 5'd0);
        x_inf  = (x[14:10] == 5'h1F) && (x[9:0] == 10'd0);
        y_inf  = (y[14:10] == 5'h1F) && (y[9:0] == 10'd0);
        x_nan  = (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
        y_nan  = (y[14:10] == 5'h1F) && (y[9:0] != 10'd0);

        prod = 22'({1'b1, x[9:0]}) * 22'({1'b1, y[9:0]});
        exp  = $signed({3'b000, x[14:10]}) + $signed({3'b000, y[14:10]})
             - $signed(8'(FP16_EXP_BIAS));

        // Product of two 1.xxx significands lies in [1,4); renormalise before rounding.
        if (prod[21]) begin
            mant   = prod[20:11];
            guard  = prod[10];
            sticky = |prod[9:0];
            exp    = exp + 8'sd1;
        end else begin
            mant   = prod[19:10];
            guard  = prod[9];
            sticky = |prod[8:0];
        end

        inc    = guard & (sticky | mant[0]);
        mant_r = {1'b0, mant} + {10'd0, inc};
        if (mant_r[10]) begin
            exp = exp + 8'sd1;
        end

        if (x_nan || y_nan || (x_inf && y_zero) || (x_zero && y_inf)) begin
            res = FP16_QNAN;
        end else if (x_inf || y_inf) begin
            res = FP16_INF | {sign, 15'd0};
        end else if (x_zero || y_zero) begin
            res = {sign, 15'd0};
        end else if (exp >= 8'sd31) begin
            res = FP16_INF | {sign, 15'd0};
        end else if (exp <= 8'sd0) begin
            res = {sign, 15'd0};
        end else begin
            res = {sign, exp[4:0], mant_r[9:0]};
        end
        return res;
    endfunction

    logic [15:0]        res_pipe [MUL_LAT];
    logic [MUL_LAT-1:0] vld_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                res_pipe[i] <= 16'd0;
            end
        end else begin
            vld_pipe[0] <= operation_nd & ~flush;
            if (operation_nd) begin
                res_pipe[0] <= mul_core(a, b);
            end
            for (int i = 1; i < MUL_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1] & ~flush;
                res_pipe[i] <= res_pipe[i-1];
            end
        end
    end

    assign result = res_pipe[MUL_LAT-1];
    assign rdy    = vld_pipe[MUL_LAT-1];

endmodule

// File: rtl/pool_scale.sv
// Scales each fp16 window sum by the layer's 1/kernel_size, writes the average to the
// output FIFO and pulses done once out_total results of the layer have been written.
module pool_scale
    import pool_scale_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      kernel_recip,
    input  logic [CNT_W-1:0] out_total,
    input  logic [15:0]      csum_result,
    input  logic             csum_ready,
    input  logic             fifo_full,
    output logic             wr_en,
    output logic [15:0]      wr_data,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output state_t           dbg_state
);

    // Handshakes: csum_ready is a one-cycle pulse with no backpressure, so it is only
    // taken in IDLE (else dropped and flagged); a FIFO write happens in any cycle with
    // wr_en=1, and wr_en is only raised while fifo_full=0.
    state_t           state, state_next;
    logic [15:0]      recip_q, operand_q, hold_q, mul_result;
    logic [CNT_W-1:0] total_q, cnt, cnt_inc;
    logic             op_nd, mul_rdy;
    logic             capture, drop, load_hold, last_write;

    fp16_mul #(.MUL_LAT(MUL_LAT)) u_mul (
        .clk          (clk),
        .rst          (rst),
        .flush        (start),
        .a            (operand_q),
        .b            (recip_q),
        .operation_nd (op_nd),
        .result       (mul_result),
        .rdy          (mul_rdy)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (start) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (csum_ready) state_next = ST_MUL;
                ST_MUL:  if (mul_rdy)    state_next = fifo_full ? ST_HOLD : ST_IDLE;
                ST_HOLD: if (!fifo_full) state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        wr_en     = 1'b0;
        wr_data   = hold_q;
        capture   = 1'b0;
        drop      = 1'b0;
        load_hold = 1'b0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE: capture = csum_ready & ~start;
            ST_MUL: begin
                drop = csum_ready & ~start;
                if (mul_rdy) begin
                    wr_data   = mul_result;
                    wr_en     = ~fifo_full & ~start;
                    load_hold = ~start;
                end
            end
            ST_HOLD: begin
                drop  = csum_ready & ~start;
                wr_en = ~fifo_full & ~start;
            end
            default: ;
        endcase
    end

    assign dbg_state  = state;
    assign cnt_inc    = cnt + CNT_W'(1);
    // A zero total never matches, even when the counter wraps.
    assign last_write = (total_q != '0) && (cnt_inc == total_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            recip_q   <= 16'd0;
            total_q   <= '0;
            operand_q <= 16'd0;
            hold_q    <= 16'd0;
            cnt       <= '0;
            op_nd     <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            op_nd <= capture;
            if (capture) begin
                operand_q <= csum_result;
            end
            if (load_hold) begin
                hold_q <= mul_result;
            end
            if (start) begin
                recip_q  <= kernel_recip;
                total_q  <= out_total;
                cnt      <= '0;
                done     <= 1'b0;
                overflow <= 1'b0;
            end else begin
                done <= wr_en & last_write;
                if (wr_en) begin
                    cnt <= last_write ? '0 : cnt_inc;
                end
                if (drop) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/pool_scale.md
Name: pool_scale

Overview:
- Downstream neighbour of the channel-sum stage in the average-pooling path.
- Takes each fp16 window sum and multiplies it by a per-layer fp16 reciprocal of the window size, giving the window average.
- Writes the average into the output FIFO.
- Counts results against a per-layer total and pulses done when the layer is complete.

Parameters:
- MUL_LAT, 3, pipeline depth of the fp16 multiplier in cycles (>=1).
- CNT_W, 16, width of the output counter and of out_total.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle pulse. Latches kernel_recip and out_total, clears the counter, done and overflow.
- kernel_recip  in  16  fp16 value of 1/kernel_size. Sampled only on start.
- out_total  in  CNT_W  number of results expected this layer. Sampled only on start.
- csum_result  in  16  fp16 window sum from the channel-sum stage.
- csum_ready  in  1  one-cycle pulse; csum_result is valid in the same cycle.
- fifo_full  in  1  output FIFO full.
- wr_en  out  1  output FIFO write strobe.
- wr_data  out  16  fp16 average.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse after the last write of the layer.
- overflow  out  1  sticky error flag: a csum_ready pulse was dropped.

Behaviour:
- Reset values: all outputs 0. Latched kernel_recip = 0, latched out_total = 0, counter = 0, state = IDLE.
- States: IDLE, MUL, HOLD.
  - IDLE: on csum_ready, capture csum_result into the operand register and go to MUL. The multiplier operation_nd is pulsed on the following cycle.
  - MUL: wait for the multiplier result, which appears MUL_LAT cycles after operation_nd.
    - Result cycle with !fifo_full: wr_en=1 and wr_data=result in that cycle; increment the counter; go to IDLE.
    - Result cycle with fifo_full: store the result in the output register and go to HOLD.
  - HOLD: output register held unchanged. On the first cycle with !fifo_full, assert wr_en for one cycle, increment the counter, go to IDLE.
- Latency with FIFO not full: csum_ready at cycle t gives wr_en at cycle t+1+MUL_LAT.
- Throughput: one result in flight. This is sufficient because the upstream stage spaces results at least kernel_size+acc latency cycles apart.
- Dropped input: csum_ready while state is not IDLE is dropped and sets overflow. overflow clears only on rst or start.
- Layer completion: when the increment makes counter == latched out_total, pulse done in the cycle after that write and clear the counter.
  - out_total = 0 means no done is ever generated.
- start:
  - start while busy: the in-flight result is discarded, with no wr_en.
  - start and csum_ready in the same cycle: start wins and the pulse is ignored.
- Reset mid-operation: returns to IDLE immediately. No partial write occurs.
- fp16 multiply rules (IEEE half precision):
  - Rounding: round-to-nearest-even.
  - Subnormal inputs are treated as zero. Subnormal results flush to zero; the sign is kept.
  - Overflow gives signed infinity.
  - Any NaN, or inf*0, gives 16'h7E00.
  - inf times a finite nonzero value gives signed infinity.
  - Result sign = XOR of the operand signs, including for zero results.

Decomposition:
- Shared macros header holds: FP16_QNAN (16'h7E00), FP16_INF (16'h7C00), FP16_EXP_BIAS (15), and the state encodings.
- One sub-module, fp16_mul: pipelined multiplier with a/b/operation_nd in and result/rdy out, latency MUL_LAT.
- pool_scale contains only the FSM, the counter, the holding register and the flags.

Test Plan:
- Exact-tie rounding: start with recip=16'h2F1C (1/9), total=1; csum_result=16'h4880 (9.0) -> wr_data=16'h3C00 at cycle t+4; done pulses the next cycle.
- Basic scaling: recip=16'h3400 (0.25), sums 16'h4400 and 16'hC400 -> wr_data 16'h3C00 then 16'hBC00.
- Backpressure: fifo_full=1 from t to t+10 -> state HOLD, no wr_en, wr_data stable; fifo_full drops at t+10 -> a single wr_en=1 with 16'h3C00 at t+10.
- Special values: 16'h7BFF×16'h4000 -> 16'h7C00; 16'h7C00×16'h0000 -> 16'h7E00; subnormal 16'h0001×16'h3C00 -> 16'h0000.
- Overflow and start: second csum_ready at t+2 -> overflow=1 and only one write; a later start clears overflow; start at t+2 with one result in flight -> no wr_en.
- Async reset at t+2 -> wr_en, busy, done and overflow all 0 immediately; the next csum_ready is processed normally.
